// File: rtl/lsu_icb_ctrl.sv
// LSU front end: one-outstanding bridge from the AGU ICB command channel to a word memory port.
// Optional build macro LSU_MISALIGN_CHK_EN answers misaligned half/word accesses with an error.
module lsu_icb_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   agu_icb_cmd_valid,
  output logic                   agu_icb_cmd_ready,
  input  logic [ADDR_SIZE-1:0]   agu_icb_cmd_addr,
  input  logic                   agu_icb_cmd_read,
  input  logic [XLEN-1:0]        agu_icb_cmd_wdata,
  input  logic [XLEN/8-1:0]      agu_icb_cmd_wmask,
  input  logic [1:0]             agu_icb_cmd_size,
  input  logic                   agu_icb_cmd_usign,
  input  logic [RFIDX_WIDTH-1:0] agu_icb_cmd_rdidx,
  output logic                   agu_icb_rsp_valid,
  input  logic                   agu_icb_rsp_ready,
  output logic [XLEN-1:0]        agu_icb_rsp_rdata,
  output logic [RFIDX_WIDTH-1:0] agu_icb_rsp_rdidx,
  output logic                   agu_icb_rsp_err,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_SIZE-1:0]   mem_req_addr,
  output logic                   mem_req_wen,
  output logic [XLEN-1:0]        mem_req_wdata,
  output logic [XLEN/8-1:0]      mem_req_wmask,
  input  logic                   mem_rsp_valid,
  input  logic [XLEN-1:0]        mem_rsp_rdata,
  input  logic                   mem_rsp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

  state_e                 r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic                   r_read;
  logic [1:0]             r_size;
  logic                   r_usign;
  logic [RFIDX_WIDTH-1:0] r_rdidx;
  logic [XLEN-1:0]        r_wdata;
  logic [XLEN/8-1:0]      r_wmask;
  logic [XLEN-1:0]        r_rdata;
  logic                   r_err;

  logic                   w_cmd_hsk;
  logic                   w_misalign;
  logic [4:0]             w_off_bits;
  logic [XLEN-1:0]        w_ld_shift;
  logic [XLEN-1:0]        w_ld_ext;

  assign w_cmd_hsk  = agu_icb_cmd_valid & (r_state == StIdle);
  assign w_off_bits = {r_addr[1:0], 3'b000};

`ifdef LSU_MISALIGN_CHK_EN
  // Size 3 is a word access, so bit 1 of size selects the word alignment rule.
  assign w_misalign = ((agu_icb_cmd_size == 2'd1) & agu_icb_cmd_addr[0]) |
                      (agu_icb_cmd_size[1] & (|agu_icb_cmd_addr[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    agu_icb_cmd_ready = 1'b0;
    mem_req_valid     = 1'b0;
    agu_icb_rsp_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        agu_icb_cmd_ready = 1'b1;
        if (agu_icb_cmd_valid) w_state_nxt = w_misalign ? StRsp : StReq;
      end
      StReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) w_state_nxt = StRsp;
      end
      StRsp: begin
        agu_icb_rsp_valid = 1'b1;
        if (agu_icb_rsp_ready) w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    w_ld_shift = mem_rsp_rdata >> w_off_bits;
    case (r_size)
      2'd0:    w_ld_ext = {{(XLEN-8){~r_usign & w_ld_shift[7]}}, w_ld_shift[7:0]};
      2'd1:    w_ld_ext = {{(XLEN-16){~r_usign & w_ld_shift[15]}}, w_ld_shift[15:0]};
      default: w_ld_ext = w_ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_size  <= 2'd0;
      r_usign <= 1'b0;
      r_rdidx <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_hsk) begin
        r_addr  <= agu_icb_cmd_addr;
        r_read  <= agu_icb_cmd_read;
        r_size  <= agu_icb_cmd_size;
        r_usign <= agu_icb_cmd_usign;
        r_rdidx <= agu_icb_cmd_rdidx;
        r_wdata <= agu_icb_cmd_wdata;
        r_wmask <= agu_icb_cmd_wmask;
        r_rdata <= '0;
        r_err   <= w_misalign;
      end else if ((r_state == StWait) && mem_rsp_valid) begin
        // Stores and faulted accesses return zero data.
        r_rdata <= (r_read && !mem_rsp_err) ? w_ld_ext : '0;
        r_err   <= mem_rsp_err;
      end
    end
  end

  assign mem_req_addr      = {r_addr[ADDR_SIZE-1:2], 2'b00};
  assign mem_req_wen       = ~r_read;
  assign mem_req_wdata     = r_wdata << w_off_bits;
  assign mem_req_wmask     = r_wmask << r_addr[1:0];
  assign agu_icb_rsp_rdata = r_rdata;
  assign agu_icb_rsp_rdidx = r_rdidx;
  assign agu_icb_rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_icb_ctrl.sv
// Directed and randomized bench for lsu_icb_ctrl; the bench plays the execute stage and the memory.
module tb_lsu_icb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        agu_icb_cmd_valid;
  logic        agu_icb_cmd_ready;
  logic [31:0] agu_icb_cmd_addr;
  logic        agu_icb_cmd_read;
  logic [31:0] agu_icb_cmd_wdata;
  logic [3:0]  agu_icb_cmd_wmask;
  logic [1:0]  agu_icb_cmd_size;
  logic        agu_icb_cmd_usign;
  logic [4:0]  agu_icb_cmd_rdidx;
  logic        agu_icb_rsp_valid;
  logic        agu_icb_rsp_ready;
  logic [31:0] agu_icb_rsp_rdata;
  logic [4:0]  agu_icb_rsp_rdidx;
  logic        agu_icb_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_icb_ctrl #(.XLEN(32), .ADDR_SIZE(32), .RFIDX_WIDTH(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .agu_icb_cmd_valid (agu_icb_cmd_valid),
    .agu_icb_cmd_ready (agu_icb_cmd_ready),
    .agu_icb_cmd_addr  (agu_icb_cmd_addr),
    .agu_icb_cmd_read  (agu_icb_cmd_read),
    .agu_icb_cmd_wdata (agu_icb_cmd_wdata),
    .agu_icb_cmd_wmask (agu_icb_cmd_wmask),
    .agu_icb_cmd_size  (agu_icb_cmd_size),
    .agu_icb_cmd_usign (agu_icb_cmd_usign),
    .agu_icb_cmd_rdidx (agu_icb_cmd_rdidx),
    .agu_icb_rsp_valid (agu_icb_rsp_valid),
    .agu_icb_rsp_ready (agu_icb_rsp_ready),
    .agu_icb_rsp_rdata (agu_icb_rsp_rdata),
    .agu_icb_rsp_rdidx (agu_icb_rsp_rdidx),
    .agu_icb_rsp_err   (agu_icb_rsp_err),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_req_wen       (mem_req_wen),
    .mem_req_wdata     (mem_req_wdata),
    .mem_req_wmask     (mem_req_wmask),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_rdata     (mem_rsp_rdata),
    .mem_rsp_err       (mem_rsp_err)
  );

  task automatic check(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // Reference: pick the addressed bytes out of the word and extend them numerically.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input int size,
                                           input bit usign);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word >> (8 * off);
    if (size == 0) begin
      v = sh % 256;
      if (!usign && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = sh % 65536;
      if (!usign && v >= 32768) v = v - 65536;
    end else begin
      v = sh;
    end
    return v;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] addr, input int size);
    bit en;
`ifdef LSU_MISALIGN_CHK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && ((size == 1 && addr % 2 != 0) || (size >= 2 && addr % 4 != 0));
  endfunction

  task automatic check_rsp(input string tag, input logic [31:0] rdata, input bit err,
                           input logic [4:0] rdidx);
    check(tag, "rsp_valid", 32'(agu_icb_rsp_valid), 32'd1);
    check(tag, "rsp_rdata", agu_icb_rsp_rdata, rdata);
    check(tag, "rsp_err", 32'(agu_icb_rsp_err), 32'(err));
    check(tag, "rsp_rdidx", 32'(agu_icb_rsp_rdidx), 32'(rdidx));
  endtask

  task automatic txn(input string tag, input bit rd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask, input logic [1:0] size,
                     input bit usign, input logic [4:0] rdidx, input logic [31:0] mword,
                     input bit merr, input int req_dly, input int rsp_dly, input int rdy_dly);
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    bit          exp_err;
    int          off;
    off       = int'(addr % 4);
    exp_wdata = wdata << (8 * off);
    exp_wmask = wmask << off;
    @(negedge clk);
    check(tag, "cmd_ready_idle", 32'(agu_icb_cmd_ready), 32'd1);
    agu_icb_cmd_valid = 1'b1;
    agu_icb_cmd_addr  = addr;
    agu_icb_cmd_read  = rd;
    agu_icb_cmd_wdata = wdata;
    agu_icb_cmd_wmask = wmask;
    agu_icb_cmd_size  = size;
    agu_icb_cmd_usign = usign;
    agu_icb_cmd_rdidx = rdidx;
    @(posedge clk);
    @(negedge clk);
    agu_icb_cmd_valid = 1'b0;
    agu_icb_cmd_addr  = $urandom;
    agu_icb_cmd_rdidx = 5'($urandom);
    check(tag, "cmd_ready_busy", 32'(agu_icb_cmd_ready), 32'd0);
    if (ref_misaligned(addr, int'(size))) begin
      check(tag, "no_mem_req", 32'(mem_req_valid), 32'd0);
      exp_err   = 1'b1;
      exp_rdata = 32'd0;
    end else begin
      for (int i = 0; i <= req_dly; i++) begin
        check(tag, "req_valid", 32'(mem_req_valid), 32'd1);
        check(tag, "req_addr", mem_req_addr, addr - off);
        check(tag, "req_wen", 32'(mem_req_wen), 32'(!rd));
        if (!rd) begin
          check(tag, "req_wdata", mem_req_wdata, exp_wdata);
          check(tag, "req_wmask", 32'(mem_req_wmask), 32'(exp_wmask));
        end
        if (i == req_dly) begin
          mem_req_ready = 1'b1;
          @(posedge clk);
          @(negedge clk);
          mem_req_ready = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
      for (int i = 0; i <= rsp_dly; i++) begin
        check(tag, "wait_no_req", 32'(mem_req_valid), 32'd0);
        check(tag, "wait_no_rsp", 32'(agu_icb_rsp_valid), 32'd0);
        if (i < rsp_dly) @(negedge clk);
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = mword;
      mem_rsp_err   = merr;
      @(posedge clk);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      exp_err   = merr;
      exp_rdata = (rd && !merr) ? ref_load(mword, off, int'(size), usign) : 32'd0;
    end
    // Stray memory responses while the result is pending must not disturb it.
    for (int i = 0; i < rdy_dly; i++) begin
      check_rsp(tag, exp_rdata, exp_err, rdidx);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = $urandom;
      mem_rsp_err   = 1'b1;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    check_rsp(tag, exp_rdata, exp_err, rdidx);
    agu_icb_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    agu_icb_rsp_ready = 1'b0;
    check(tag, "rsp_done", 32'(agu_icb_rsp_valid), 32'd0);
    check(tag, "cmd_ready_again", 32'(agu_icb_cmd_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [3:0]  msk;
    rst_n             = 1'b0;
    agu_icb_cmd_valid = 1'b0;
    agu_icb_cmd_addr  = '0;
    agu_icb_cmd_read  = 1'b0;
    agu_icb_cmd_wdata = '0;
    agu_icb_cmd_wmask = '0;
    agu_icb_cmd_size  = '0;
    agu_icb_cmd_usign = 1'b0;
    agu_icb_cmd_rdidx = '0;
    agu_icb_rsp_ready = 1'b0;
    mem_req_ready     = 1'b0;
    mem_rsp_valid     = 1'b0;
    mem_rsp_rdata     = '0;
    mem_rsp_err       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset", "cmd_ready", 32'(agu_icb_cmd_ready), 32'd1);
    check("reset", "req_valid", 32'(mem_req_valid), 32'd0);
    check("reset", "rsp_valid", 32'(agu_icb_rsp_valid), 32'd0);
    check("reset", "rsp_rdata", agu_icb_rsp_rdata, 32'd0);
    check("reset", "rsp_err", 32'(agu_icb_rsp_err), 32'd0);
    check("reset", "rsp_rdidx", 32'(agu_icb_rsp_rdidx), 32'd0);

    txn("st_word", 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 2'd2, 1'b0, 5'd0,
        32'h1234_5678, 1'b0, 0, 0, 0);
    txn("st_byte", 1'b0, 32'h8000_0003, 32'h0000_00AB, 4'b0001, 2'd0, 1'b0, 5'd0,
        32'h0, 1'b0, 0, 1, 0);
    txn("ld_b_s", 1'b1, 32'h8000_0002, 32'h0, 4'b0001, 2'd0, 1'b0, 5'd7,
        32'h12F4_5678, 1'b0, 0, 0, 0);
    txn("ld_b_u", 1'b1, 32'h8000_0002, 32'h0, 4'b0001, 2'd0, 1'b1, 5'd19,
        32'h12F4_5678, 1'b0, 0, 0, 1);
    txn("ld_h_stall", 1'b1, 32'h8000_0002, 32'h0, 4'b0011, 2'd1, 1'b0, 5'd11,
        32'h8001_ABCD, 1'b0, 3, 1, 2);
    txn("ld_w_err", 1'b1, 32'h8000_0008, 32'h0, 4'b1111, 2'd2, 1'b0, 5'd3,
        32'hCAFE_F00D, 1'b1, 0, 2, 0);
    txn("ld_w_mis", 1'b1, 32'h8000_0001, 32'h0, 4'b1111, 2'd2, 1'b0, 5'd5,
        32'hA1B2_C3D4, 1'b0, 0, 0, 0);
    txn("ld_sz3", 1'b1, 32'h8000_0010, 32'h0, 4'b1111, 2'd3, 1'b1, 5'd9,
        32'h8765_4321, 1'b0, 1, 0, 0);

    // Reset while waiting on memory drops the access.
    @(negedge clk);
    agu_icb_cmd_valid = 1'b1;
    agu_icb_cmd_read  = 1'b1;
    agu_icb_cmd_addr  = 32'h8000_0020;
    agu_icb_cmd_size  = 2'd2;
    @(posedge clk);
    @(negedge clk);
    agu_icb_cmd_valid = 1'b0;
    check("rst_wait", "req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_wait", "req_valid_rst", 32'(mem_req_valid), 32'd0);
    check("rst_wait", "rsp_valid_rst", 32'(agu_icb_rsp_valid), 32'd0);
    check("rst_wait", "cmd_ready_rst", 32'(agu_icb_cmd_ready), 32'd1);
    @(negedge clk);
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_wait", "no_rsp_after", 32'(agu_icb_rsp_valid), 32'd0);
      check("rst_wait", "no_req_after", 32'(mem_req_valid), 32'd0);
    end
    mem_rsp_valid = 1'b0;

    // Reset while a response is pending clears it at once.
    @(negedge clk);
    agu_icb_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    agu_icb_cmd_valid = 1'b0;
    mem_req_ready     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rst_rsp", "rsp_valid_pre", 32'(agu_icb_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rsp", "rsp_valid_rst", 32'(agu_icb_rsp_valid), 32'd0);
    check("rst_rsp", "rsp_rdata_rst", agu_icb_rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      case (sz)
        2'd0:    msk = 4'b0001;
        2'd1:    msk = 4'b0011;
        default: msk = 4'b1111;
      endcase
      txn($sformatf("rand%0d", n), 1'($urandom), 32'h8000_0000 | ($urandom & 32'h0000_FFFF),
          $urandom, msk, sz, 1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
